// File: rtl/hazard_scoreboard_if.sv
// hazard_scoreboard_if: ID-stage request and stall-control bundle between the ID stage and the hazard scoreboard.
//   master: ID stage; drives the decoded instruction fields and flush, and receives the stall controls.
//   slave:  scoreboard; receives the decoded fields and drives stall, pc_write, ifid_write,
//           idex_bubble, stall_cause, mdu_busy and stall_cycles.
interface hazard_scoreboard_if #(
    parameter int REG_W  = 5,
    parameter int PERF_W = 32
);
    logic              id_valid;
    logic [REG_W-1:0]  id_rs;
    logic [REG_W-1:0]  id_rt;
    logic              id_use_rs;
    logic              id_use_rt;
    logic              id_is_branch;
    logic              id_writes;
    logic [REG_W-1:0]  id_dst;
    logic              id_is_load;
    logic              id_is_mdu;
    logic              id_uses_mdu;
    logic              flush;
    logic              stall;
    logic              pc_write;
    logic              ifid_write;
    logic              idex_bubble;
    logic [1:0]        stall_cause;
    logic              mdu_busy;
    logic [PERF_W-1:0] stall_cycles;

    modport master (
        output id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_is_branch,
               id_writes, id_dst, id_is_load, id_is_mdu, id_uses_mdu, flush,
        input  stall, pc_write, ifid_write, idex_bubble, stall_cause, mdu_busy, stall_cycles
    );

    modport slave (
        input  id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_is_branch,
               id_writes, id_dst, id_is_load, id_is_mdu, id_uses_mdu, flush,
        output stall, pc_write, ifid_write, idex_bubble, stall_cause, mdu_busy, stall_cycles
    );
endinterface

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: counter-based data/MDU hazard unit beside ID; drives stall controls and a stall-cycle counter.
//   clk   : rising-edge clock
//   reset : asynchronous active-high reset; clears all counters
//   hs    : slave side of hazard_scoreboard_if (instruction fields in, stall controls out)
module hazard_scoreboard #(
    parameter int REG_W       = 5,
    parameter int ALU_EX_LAT  = 0,
    parameter int ALU_ID_LAT  = 2,
    parameter int LOAD_EX_LAT = 1,
    parameter int LOAD_ID_LAT = 2,
    parameter int MDU_LAT     = 4,
    parameter int CNT_W       = 3,
    parameter int PERF_W      = 32
) (
    input logic                clk,
    input logic                reset,
    hazard_scoreboard_if.slave hs
);
    localparam int NUM_REGS = 2 ** REG_W;

    // Entry 0 is never loaded (loads require a nonzero destination), so it stays 0.
    logic [CNT_W-1:0]  ex_cnt [NUM_REGS];
    logic [CNT_W-1:0]  id_cnt [NUM_REGS];
    logic [CNT_W-1:0]  mdu_cnt;
    logic [PERF_W-1:0] stall_cycles;
    logic [CNT_W-1:0]  cnt_rs, cnt_rt, ld_ex, ld_id;
    logic              hit_rs, hit_rt, data_hz, mdu_hz, stall, issue, wr;

    assign cnt_rs  = hs.id_is_branch ? id_cnt[hs.id_rs] : ex_cnt[hs.id_rs];
    assign cnt_rt  = hs.id_is_branch ? id_cnt[hs.id_rt] : ex_cnt[hs.id_rt];
    assign hit_rs  = hs.id_use_rs && hs.id_rs != '0 && cnt_rs != '0;
    assign hit_rt  = hs.id_use_rt && hs.id_rt != '0 && cnt_rt != '0;
    assign data_hz = hit_rs || hit_rt;
    assign mdu_hz  = hs.id_uses_mdu && mdu_cnt != '0;
    assign stall   = hs.id_valid && !hs.flush && (data_hz || mdu_hz);
    assign issue   = hs.id_valid && !hs.flush && !stall;
    assign wr      = issue && hs.id_writes && hs.id_dst != '0;

    // MDU class wins over load when both flags are set.
    assign ld_ex = hs.id_is_mdu ? CNT_W'(MDU_LAT) : hs.id_is_load ? CNT_W'(LOAD_EX_LAT) : CNT_W'(ALU_EX_LAT);
    assign ld_id = hs.id_is_mdu ? CNT_W'(MDU_LAT) : hs.id_is_load ? CNT_W'(LOAD_ID_LAT) : CNT_W'(ALU_ID_LAT);

    assign hs.stall        = stall;
    assign hs.pc_write     = ~stall;
    assign hs.ifid_write   = ~stall;
    assign hs.idex_bubble  = stall;
    assign hs.stall_cause  = !stall ? 2'd0 : data_hz ? (hs.id_is_branch ? 2'd2 : 2'd1) : 2'd3;
    assign hs.mdu_busy     = mdu_cnt != '0;
    assign hs.stall_cycles = stall_cycles;

    // A load on issue replaces the decremented value, including any older pending count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                ex_cnt[r] <= '0;
                id_cnt[r] <= '0;
            end
            mdu_cnt      <= '0;
            stall_cycles <= '0;
        end else begin
            for (int r = 0; r < NUM_REGS; r++) begin
                ex_cnt[r] <= (wr && hs.id_dst == REG_W'(r)) ? ld_ex : ex_cnt[r] - CNT_W'(ex_cnt[r] != '0);
                id_cnt[r] <= (wr && hs.id_dst == REG_W'(r)) ? ld_id : id_cnt[r] - CNT_W'(id_cnt[r] != '0);
            end
            mdu_cnt      <= (issue && hs.id_is_mdu) ? CNT_W'(MDU_LAT) : mdu_cnt - CNT_W'(mdu_cnt != '0);
            stall_cycles <= stall_cycles + PERF_W'(stall && !(&stall_cycles));
        end
    end
endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: directed-vector self-checking bench for hazard_scoreboard.
module tb_hazard_scoreboard;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   n, nb;
    logic [1:0] c;

    hazard_scoreboard_if hs ();

    hazard_scoreboard dut (
        .clk   (clk),
        .reset (reset),
        .hs    (hs)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic idle();
        hs.id_valid = 0; hs.id_rs = 0; hs.id_rt = 0; hs.id_use_rs = 0; hs.id_use_rt = 0;
        hs.id_is_branch = 0; hs.id_writes = 0; hs.id_dst = 0; hs.id_is_load = 0;
        hs.id_is_mdu = 0; hs.id_uses_mdu = 0; hs.flush = 0;
    endtask

    task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic urs, input logic urt,
                         input logic br, input logic wr, input logic [4:0] dst, input logic ld,
                         input logic md, input logic um, input logic fl);
        hs.id_valid = 1; hs.id_rs = rs; hs.id_rt = rt; hs.id_use_rs = urs; hs.id_use_rt = urt;
        hs.id_is_branch = br; hs.id_writes = wr; hs.id_dst = dst; hs.id_is_load = ld;
        hs.id_is_mdu = md; hs.id_uses_mdu = um; hs.flush = fl;
    endtask

    // Hold the driven instruction until it leaves ID; returns stall count, first cause, busy cycles.
    task automatic step(output int ns, output logic [1:0] cause, output int busy);
        ns = 0; cause = 0; busy = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (hs.mdu_busy) busy++;
            if (!hs.stall) break;
            if (ns == 0) cause = hs.stall_cause;
            ns++;
        end
        @(posedge clk); #1;
        idle();
    endtask

    initial begin
        idle();
        #3;
        check("rst_stall", hs.stall, 0);
        check("rst_pc_write", hs.pc_write, 1);
        check("rst_ifid_write", hs.ifid_write, 1);
        check("rst_bubble", hs.idex_bubble, 0);
        check("rst_cause", hs.stall_cause, 0);
        check("rst_busy", hs.mdu_busy, 0);
        check("rst_cycles", hs.stall_cycles, 0);
        @(posedge clk); #1 reset = 0;

        // Reset while a stall is showing: released without waiting for an edge.
        drive(0, 0, 0, 0, 0, 1, 9, 1, 0, 0, 0); step(n, c, nb);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0); step(n, c, nb);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        #1;
        check("pre_rst_stall", hs.stall, 1);
        check("pre_rst_cause", hs.stall_cause, 3);
        @(posedge clk); #2;
        check("pre_rst_cycles", hs.stall_cycles, 1);
        reset = 1;
        #1;
        check("mid_rst_stall", hs.stall, 0);
        check("mid_rst_pc_write", hs.pc_write, 1);
        check("mid_rst_busy", hs.mdu_busy, 0);
        check("mid_rst_cause", hs.stall_cause, 0);
        check("mid_rst_cycles", hs.stall_cycles, 0);
        idle();
        @(posedge clk); #1 reset = 0;

        drive(0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0); step(n, c, nb);
        drive(1, 0, 1, 0, 0, 1, 2, 0, 0, 0, 0); step(n, c, nb);
        check("alu_alu_stalls", n, 0);

        drive(0, 0, 0, 0, 0, 1, 3, 1, 0, 0, 0); step(n, c, nb);
        drive(3, 5, 1, 1, 0, 1, 4, 0, 0, 0, 0); step(n, c, nb);
        check("load_use_stalls", n, 1);
        check("load_use_cause", c, 1);
        check("cycles_after_load", hs.stall_cycles, 1);

        drive(0, 0, 0, 0, 0, 1, 6, 0, 0, 0, 0); step(n, c, nb);
        drive(6, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0); step(n, c, nb);
        check("alu_branch_stalls", n, 2);
        check("alu_branch_cause", c, 2);

        drive(0, 0, 0, 0, 0, 1, 6, 0, 0, 0, 0); step(n, c, nb);
        drive(0, 0, 0, 0, 0, 1, 11, 0, 0, 0, 0); step(n, c, nb);
        drive(6, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0); step(n, c, nb);
        check("alu_gap_branch_stalls", n, 1);
        check("alu_gap_branch_cause", c, 2);
        check("cycles_after_branch", hs.stall_cycles, 4);

        drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0); step(n, c, nb);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0); step(n, c, nb);
        check("mdu_stalls", n, 4);
        check("mdu_cause", c, 3);
        check("mdu_busy_cycles", nb, 4);
        check("cycles_after_mdu", hs.stall_cycles, 8);

        drive(0, 0, 0, 0, 0, 1, 7, 1, 0, 0, 1); step(n, c, nb);
        drive(7, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0); step(n, c, nb);
        check("flushed_load_stalls", n, 0);

        // Flush over a live hazard: no stall, counter still decays to 0.
        drive(0, 0, 0, 0, 0, 1, 12, 1, 0, 0, 0); step(n, c, nb);
        drive(12, 0, 1, 0, 0, 1, 13, 0, 0, 0, 1);
        #1;
        check("flush_hazard_stall", hs.stall, 0);
        check("flush_hazard_pc_write", hs.pc_write, 1);
        step(n, c, nb);
        drive(12, 0, 1, 0, 0, 1, 13, 0, 0, 0, 0); step(n, c, nb);
        check("after_flush_stalls", n, 0);

        drive(0, 0, 0, 0, 0, 1, 8, 1, 0, 0, 0); step(n, c, nb);
        drive(0, 0, 1, 1, 0, 1, 5, 0, 0, 0, 0); step(n, c, nb);
        check("r0_consumer_stalls", n, 0);
        drive(0, 0, 0, 0, 0, 1, 8, 1, 0, 0, 0); step(n, c, nb);
        drive(0, 0, 0, 0, 0, 1, 8, 0, 0, 0, 0); step(n, c, nb);
        check("reload_writer_stalls", n, 0);
        drive(8, 0, 1, 0, 0, 1, 9, 0, 0, 0, 0); step(n, c, nb);
        check("reload_consumer_stalls", n, 0);

        drive(0, 0, 0, 0, 0, 1, 15, 1, 0, 0, 0); step(n, c, nb);
        drive(0, 15, 1, 1, 1, 0, 0, 0, 0, 0, 0); step(n, c, nb);
        check("load_branch_stalls", n, 2);
        check("load_branch_cause", c, 2);
        check("cycles_final", hs.stall_cycles, 10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Parametrised, counter-based hazard unit for the pipelined MIPS core, sitting beside the ID stage and replacing fixed-pattern EX/MEM register compares. It keeps a per-register countdown of remaining stall cycles for EX-stage and ID-stage (branch-compare) consumers, and a busy counter for the multi-cycle multiply/divide unit (MDU). From these it drives PC/IF-ID write enables and the ID/EX bubble, and it counts stall cycles for performance reporting.

## Interface
- REG_W, 5: register address width; NUM_REGS = 2**REG_W.
- ALU_EX_LAT, 0: stalls an EX consumer needs directly behind an ALU producer.
- ALU_ID_LAT, 2: stalls a branch (ID consumer) needs behind an ALU producer.
- LOAD_EX_LAT, 1: stalls an EX consumer needs behind a load.
- LOAD_ID_LAT, 2: stalls a branch needs behind a load.
- MDU_LAT, 4: MDU busy cycles; also the stall count for both consumer kinds behind an MDU result.
- CNT_W, 3: counter width; must hold the largest latency parameter.
- PERF_W, 32: stall-counter width.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high.
- id_valid  in  1  ID holds a valid instruction.
- id_rs, id_rt  in  REG_W  source register numbers.
- id_use_rs, id_use_rt  in  1  the matching source is actually read.
- id_is_branch  in  1  operands are consumed in ID.
- id_writes  in  1  instruction writes id_dst.
- id_dst  in  REG_W  destination register.
- id_is_load  in  1  producer class is load.
- id_is_mdu  in  1  producer class is MDU; starts the MDU.
- id_uses_mdu  in  1  needs a free MDU (MDU op or HI/LO read).
- flush  in  1  squash the ID instruction this cycle.
- stall  out  1  ID is held this cycle.
- pc_write, ifid_write  out  1  equal to ~stall.
- idex_bubble  out  1  insert a NOP into ID/EX; equals stall.
- stall_cause  out  2  0 none, 1 EX data, 2 ID/branch data, 3 MDU busy.
- mdu_busy  out  1  mdu_cnt != 0.
- stall_cycles  out  PERF_W  saturating count of stalled cycles.

## Operation
- State: ex_cnt[r] and id_cnt[r] (CNT_W bits each) for r = 1..NUM_REGS-1; mdu_cnt (CNT_W bits). Register 0 is never tracked and always reads as ready.
- src_hit(s) = use_s && s != 0 && (id_is_branch ? id_cnt[s] : ex_cnt[s]) != 0.
- data_hz = src_hit(rs) || src_hit(rt); mdu_hz = id_uses_mdu && mdu_cnt != 0.
- stall = id_valid && !flush && (data_hz || mdu_hz). All outputs except stall_cycles are combinational from the current state and inputs.
- Cause priority: data before structural. If data_hz: 2 when id_is_branch, else 1. Otherwise 3 if mdu_hz, else 0.
- issue = id_valid && !flush && !stall.
- Each cycle, every nonzero counter decrements by 1.
- On issue with id_writes && id_dst != 0, load (ex_cnt, id_cnt)[id_dst] by producer class:
  - ALU: (ALU_EX_LAT, ALU_ID_LAT).
  - load: (LOAD_EX_LAT, LOAD_ID_LAT).
  - MDU: (MDU_LAT, MDU_LAT).
  - id_is_mdu takes precedence over id_is_load.
- A load on issue overrides the same-cycle decrement of that register, including an older pending entry.
- On issue with id_is_mdu, mdu_cnt <= MDU_LAT.
- Flushed or stalled instructions never update the scoreboard.
- stall_cycles increments when stall = 1 and holds at all-ones.

## Timing
- Reset (asynchronous): all counters 0, stall_cycles 0. Consequently stall = 0, pc_write = ifid_write = 1, idex_bubble = 0, stall_cause = 0, mdu_busy = 0. Reset mid-stall releases the stall immediately, not at the next edge.
- Latency semantics: a consumer in ID the cycle right after its producer issued stalls exactly L cycles, then issues on cycle L+1.
- Latency 0 sets the counter to 0, meaning no stall.
- A consumer k cycles behind its producer stalls max(0, L-k+1) cycles.
- Two back-to-back writers of the same register: the second issue reloads the counter.
- flush and a hazard in the same cycle: stall = 0 and counters still decrement.

## Test plan
- Reset asserted mid-sequence with counters loaded → all outputs at reset values in the same cycle; after release, add r1 followed by add r2,r1 → zero stalls.
- lw r3, then add r4,r3,r5 in the next ID → 1 stall cycle, stall_cause = 1; stall_cycles = 1 afterwards.
- add r6, then beq r6,r0 → 2 stall cycles, cause 2. Repeat with one independent instruction between them → 1 stall.
- mult (id_is_mdu) then mfhi (id_uses_mdu) immediately → 4 stall cycles, cause 3, mdu_busy high for 4 cycles.
- lw r7 with flush = 1 → no scoreboard update; a following beq r7 issues with no stall.
- lw r8, then add r0 as consumer via r0 → no stall. Then lw r8 followed by add r8 (an ALU write) next cycle → ex_cnt[8] reloaded to ALU_EX_LAT = 0, so a third instruction reading r8 does not stall.
